// File: rtl/mul25_seq_pkg.sv
// mul25_seq_pkg: shared FPAU mantissa widths, iteration count and multiplier FSM states
package mul25_seq_pkg;
  localparam int MANT_W = 25;
  localparam int PROD_W = 50;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_LAST = 5'd24;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mul25_seq_if.sv
// mul25_seq_if: operand and result valid/ready handshakes of the mantissa multiplier
interface mul25_seq_if
  import mul25_seq_pkg::*;
#(
  parameter int W = MANT_W
);
  logic in_valid;
  logic in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic out_valid;
  logic out_ready;
  logic [2*W-1:0] P;
  logic [W-1:0] S;
  logic norm;
  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P, S, norm
  );
  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P, S, norm
  );
endinterface

// File: rtl/mul25_step.sv
// mul25_step: one radix-2 shift-add iteration on the {acc, mplr} pair
module mul25_step
  import mul25_seq_pkg::*;
(
  input  logic [MANT_W:0]   acc,
  input  logic [MANT_W-1:0] mplr,
  input  logic [MANT_W-1:0] mcand,
  output logic [MANT_W:0]   acc_nxt,
  output logic [MANT_W-1:0] mplr_nxt
);
  logic [MANT_W:0] w_sum;
  // acc stays below 2^25 before the add, so the 26-bit sum cannot overflow
  assign w_sum = acc + (mplr[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = {1'b0, w_sum[MANT_W:1]};
  assign mplr_nxt = {w_sum[0], mplr[MANT_W-1:1]};
endmodule

// File: rtl/mul25_seq.sv
// mul25_seq: iterative 25x25 unsigned mantissa multiplier with normalised significand output
module mul25_seq
  import mul25_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mul25_seq_if.slave bus
);
  state_t r_state, w_state_nxt;
  logic [MANT_W:0] r_acc, w_acc_nxt;
  logic [MANT_W-1:0] r_mplr, r_mcand, w_mplr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PROD_W-1:0] r_p;
  logic w_accept, w_last, w_norm;
  assign bus.in_ready = rst_n && r_state == IDLE;
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_last = r_state == CALC && r_cnt == ITER_LAST;
  mul25_step u_step (
    .acc(r_acc),
    .mplr(r_mplr),
    .mcand(r_mcand),
    .acc_nxt(w_acc_nxt),
    .mplr_nxt(w_mplr_nxt)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_accept ? CALC :
                  w_last ? DONE :
                  (r_state == DONE && bus.out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_mplr <= '0;
      r_mcand <= '0;
      r_cnt <= '0;
      r_p <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_mplr <= bus.B;
      r_mcand <= bus.A;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_mplr <= w_mplr_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      // top bit of the shifted acc is always zero, so the truncation drops nothing
      if (w_last) r_p <= PROD_W'({w_acc_nxt, w_mplr_nxt});
    end
  end
  assign w_norm = r_p[PROD_W-1];
  assign bus.out_valid = r_state == DONE;
  assign bus.P = r_p;
  assign bus.norm = w_norm;
  assign bus.S = w_norm ? r_p[PROD_W-1:MANT_W] : r_p[PROD_W-2:MANT_W-1];
endmodule

// File: tb/tb_mul25_seq.sv
// tb_mul25_seq: directed-vector self-checking bench for mul25_seq
module tb_mul25_seq;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  mul25_seq_if bus ();
  mul25_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [24:0] a, input logic [24:0] b, input logic [49:0] ep,
                     input logic [24:0] es, input logic en);
    int n;
    chk("ready_before", 64'(bus.in_ready), 64'd1);
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    bus.A = '1;
    bus.B = '1;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'd25);
    chk("P", 64'(bus.P), 64'(ep));
    chk("S", 64'(bus.S), 64'(es));
    chk("norm", 64'(bus.norm), 64'(en));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("released", 64'({bus.out_valid, bus.in_ready}), 64'b01);
  endtask
  initial begin
    int acc_t[3];
    int k, cyc, n;
    logic [49:0] held;
    logic stable;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out", 64'({bus.out_valid, bus.norm, bus.S, bus.P}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(bus.in_ready), 64'd1);
    run(25'h1000000, 25'h1000000, 50'h1000000000000, 25'h1000000, 1'b0);
    run(25'h1800000, 25'h1800000, 50'h2400000000000, 25'h1200000, 1'b1);
    run(25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001, 25'h1FFFFFE, 1'b1);
    run(25'h0000000, 25'h1234567, 50'h0, 25'h0, 1'b0);
    run(25'h1000001, 25'h1000003, 50'h1000004000003, 25'h1000004, 1'b0);
    // back-pressure: result must hold while in_valid pulses are ignored
    bus.A = 25'h1800000;
    bus.B = 25'h1000000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("bp_latency", 64'(n), 64'd25);
    held = bus.P;
    chk("bp_P", 64'(held), 64'h1800000000000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.A = 25'h0ABCDEF;
      bus.B = 25'h1555555;
      tick();
      if (bus.P !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_S", 64'(bus.S), 64'h1800000);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    // throughput with both sides always willing
    bus.A = 25'h1000000;
    bus.B = 25'h1000000;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    acc_t = '{-1000, -1000, -1000};
    k = 0;
    for (cyc = 0; cyc < 80 && k < 3; cyc++) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_t[k] = cyc;
        k++;
      end
      tick();
    end
    chk("tput_gap1", 64'(acc_t[1] - acc_t[0]), 64'd27);
    chk("tput_gap2", 64'(acc_t[2] - acc_t[1]), 64'd27);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      tick();
      n++;
    end
    chk("drain", 64'(bus.in_ready), 64'd1);
    chk("tput_P", 64'(bus.P), 64'h1000000000000);
    // reset twelve edges into a calculation
    bus.out_ready = 1'b0;
    bus.A = 25'h1FFFFFF;
    bus.B = 25'h1FFFFFF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_out", 64'({bus.out_valid, bus.norm, bus.S, bus.P}), 64'd0);
    bus.in_valid = 1'b1;
    tick();
    chk("rst_no_accept", 64'({bus.out_valid, bus.in_ready}), 64'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
    run(25'h1000000, 25'h1000000, 50'h1000000000000, 25'h1000000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
